// File: rtl/fb_swap_ctrl_pkg.sv
// Shared definitions for the framebuffer swap controller: FSM state
// encoding, address width and the last-pixel index helper.
package fb_swap_ctrl_pkg;

    localparam int unsigned ADDR_W     = 20;
    localparam int unsigned H_DISP_DEF = 1280;
    localparam int unsigned V_DISP_DEF = 720;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RENDER  = 2'd1,
        WAIT_VS = 2'd2,
        SWAP    = 2'd3
    } fb_state_e;

    // Index of the last pixel of a frame (pixels are numbered from 0).
    function automatic logic [ADDR_W-1:0] frame_pix(input int unsigned h, input int unsigned v);
        return ADDR_W'(h * v - 32'd1);
    endfunction

    localparam logic [ADDR_W-1:0] FRAME_PIX = frame_pix(H_DISP_DEF, V_DISP_DEF);

endpackage

// File: rtl/fb_addr_cnt.sv
// Pixel address counter: counts accepted pixels, wraps to 0 after the
// last pixel of a frame and flags that last pixel on tc_o.
module fb_addr_cnt
    import fb_swap_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LAST = FRAME_PIX
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              tc_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance on enable and wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffered framebuffer swap controller. Sequences render frames
// into the back bank, waits for display vsync, then swaps banks so the
// display never scans a bank that is being written.
module fb_swap_ctrl
    import fb_swap_ctrl_pkg::*;
#(
    parameter int unsigned H_DISP = H_DISP_DEF,
    parameter int unsigned V_DISP = V_DISP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              disp_vs,
    output logic              render_start,
    output logic              render_stall,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_bank,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        dup_cnt,
    output logic              ovf_err
);

    localparam logic [ADDR_W-1:0] LAST_PIX = frame_pix(H_DISP, V_DISP);

    fb_state_e         state_q, state_d;
    logic              idle_arm_q, idle_arm_d;
    logic              vs_pend_q, vs_pend_d;
    logic              render_start_q;
    logic              render_stall_q;
    logic              wr_bank_q;
    logic              rd_bank_q;
    logic [15:0]       frame_cnt_q;
    logic [7:0]        dup_cnt_q;
    logic              ovf_err_q;

    logic              pix_acc;
    logic              pix_last;
    logic              dup_inc;
    logic              swap_en;
    logic [ADDR_W-1:0] pix_cnt;

    fb_addr_cnt #(
        .LAST (LAST_PIX)
    ) u_addr_cnt (
        .clk   (clk),
        .en_i  (pix_acc),
        .clr_i (rst),
        .cnt_o (pix_cnt),
        .tc_o  (pix_last)
    );

    // Next-state logic: frame sequencing, pending-vsync capture, dup detection.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        idle_arm_d = idle_arm_q;
        vs_pend_d  = vs_pend_q;
        pix_acc    = 1'b0;
        dup_inc    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Held for one full cycle after reset release before rendering.
                idle_arm_d = 1'b1;
                dup_inc    = disp_vs;
                if (idle_arm_q) state_d = RENDER;
            end
            RENDER: begin
                pix_acc = pix_valid;
                if (pix_valid && pix_last) begin
                    state_d   = WAIT_VS;
                    // A vsync coinciding with the last pixel is not lost.
                    vs_pend_d = disp_vs;
                end else begin
                    dup_inc = disp_vs;
                end
            end
            WAIT_VS: begin
                if (disp_vs || vs_pend_q) begin
                    state_d   = SWAP;
                    vs_pend_d = 1'b0;
                end
            end
            SWAP: begin
                dup_inc = disp_vs;
                state_d = RENDER;
            end
            default: state_d = IDLE;
        endcase
    end

    assign swap_en = (state_q == WAIT_VS) && (state_d == SWAP);

    // State, bank and status registers; all registered outputs live here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idle_arm_q     <= 1'b0;
            vs_pend_q      <= 1'b0;
            render_start_q <= 1'b0;
            render_stall_q <= 1'b1;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b1;
            frame_cnt_q    <= '0;
            dup_cnt_q      <= '0;
            ovf_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idle_arm_q     <= idle_arm_d;
            vs_pend_q      <= vs_pend_d;
            render_start_q <= (state_d == RENDER) && (state_q != RENDER);
            render_stall_q <= (state_d != RENDER);
            if (swap_en) begin
                wr_bank_q   <= ~wr_bank_q;
                rd_bank_q   <= ~rd_bank_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (dup_inc && (dup_cnt_q != 8'hFF)) begin
                dup_cnt_q <= dup_cnt_q + 8'd1;
            end
            if (pix_valid && (state_q != RENDER)) begin
                ovf_err_q <= 1'b1;
            end
        end
    end

    assign render_start = render_start_q;
    assign render_stall = render_stall_q;
    assign wr_en        = pix_acc;
    assign wr_addr      = pix_cnt;
    assign wr_bank      = wr_bank_q;
    assign rd_bank      = rd_bank_q;
    assign frame_cnt    = frame_cnt_q;
    assign dup_cnt      = dup_cnt_q;
    assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed testbench for fb_swap_ctrl with a 4x2 frame.
module tb_fb_swap_ctrl;

    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic        disp_vs;
    logic        render_start;
    logic        render_stall;
    logic        wr_en;
    logic        wr_bank;
    logic [19:0] wr_addr;
    logic        rd_bank;
    logic [15:0] frame_cnt;
    logic [7:0]  dup_cnt;
    logic        ovf_err;

    int n_checks = 0;
    int n_errors = 0;

    fb_swap_ctrl #(
        .H_DISP (4),
        .V_DISP (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid    (pix_valid),
        .disp_vs      (disp_vs),
        .render_start (render_start),
        .render_stall (render_stall),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .rd_bank      (rd_bank),
        .frame_cnt    (frame_cnt),
        .dup_cnt      (dup_cnt),
        .ovf_err      (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Feed n back-to-back pixels starting at the current counter value.
    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            #1;
            check($sformatf("wr_en px%0d", base + i), 32'(wr_en), 32'd1);
            check($sformatf("wr_addr px%0d", base + i), 32'(wr_addr), 32'(base + i));
            cyc();
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        disp_vs   = 1'b0;
        repeat (3) cyc();

        // Reset values
        check("rst stall", 32'(render_stall), 32'd1);
        check("rst start", 32'(render_start), 32'd0);
        check("rst wr_bank", 32'(wr_bank), 32'd0);
        check("rst rd_bank", 32'(rd_bank), 32'd1);
        check("rst frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst dup_cnt", 32'(dup_cnt), 32'd0);
        check("rst ovf", 32'(ovf_err), 32'd0);
        check("rst wr_en", 32'(wr_en), 32'd0);

        // First render_start two cycles after reset release
        rst = 1'b0;
        cyc();
        check("c1 start", 32'(render_start), 32'd0);
        check("c1 stall", 32'(render_stall), 32'd1);
        cyc();
        check("c2 start", 32'(render_start), 32'd1);
        check("c2 stall", 32'(render_stall), 32'd0);

        // Frame 1: eight pixels, then vsync five cycles after the last one
        feed(8, 0);
        check("f1 stall waitvs", 32'(render_stall), 32'd1);
        check("f1 start low", 32'(render_start), 32'd0);
        repeat (4) cyc();
        check("f1 wait wr_bank", 32'(wr_bank), 32'd0);
        check("f1 wait frame", 32'(frame_cnt), 32'd0);
        disp_vs = 1'b1;
        cyc();
        disp_vs = 1'b0;
        check("f1 swap wr_bank", 32'(wr_bank), 32'd1);
        check("f1 swap rd_bank", 32'(rd_bank), 32'd0);
        check("f1 frame_cnt", 32'(frame_cnt), 32'd1);
        check("f1 swap start", 32'(render_start), 32'd0);
        check("f1 swap stall", 32'(render_stall), 32'd1);
        cyc();
        check("f1 restart", 32'(render_start), 32'd1);
        check("f1 restart stall", 32'(render_stall), 32'd0);

        // Frame 2: vsync on the same cycle as the last pixel
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1;
            disp_vs   = (i == 7);
            cyc();
        end
        pix_valid = 1'b0;
        disp_vs   = 1'b0;
        check("pend stall", 32'(render_stall), 32'd1);
        check("pend no swap yet", 32'(wr_bank), 32'd1);
        check("pend dup", 32'(dup_cnt), 32'd0);
        cyc();
        check("pend wr_bank", 32'(wr_bank), 32'd0);
        check("pend rd_bank", 32'(rd_bank), 32'd1);
        check("pend frame_cnt", 32'(frame_cnt), 32'd2);
        check("pend swap start", 32'(render_start), 32'd0);
        cyc();
        check("pend restart", 32'(render_start), 32'd1);
        check("pend dup after", 32'(dup_cnt), 32'd0);

        // Duplicate vsyncs during RENDER
        for (int i = 0; i < 3; i++) begin
            disp_vs = 1'b1;
            cyc();
            disp_vs = 1'b0;
            cyc();
        end
        check("dup 3", 32'(dup_cnt), 32'd3);
        check("dup wr_bank", 32'(wr_bank), 32'd0);
        check("dup rd_bank", 32'(rd_bank), 32'd1);
        check("dup frame_cnt", 32'(frame_cnt), 32'd2);
        check("dup stall", 32'(render_stall), 32'd0);
        for (int i = 0; i < 297; i++) begin
            disp_vs = 1'b1;
            cyc();
        end
        disp_vs = 1'b0;
        check("dup sat", 32'(dup_cnt), 32'd255);
        check("dup wr_addr", 32'(wr_addr), 32'd0);

        // Frame 3: pixel arriving while waiting for vsync
        feed(8, 0);
        check("ovf before", 32'(ovf_err), 32'd0);
        pix_valid = 1'b1;
        #1;
        check("ovf wr_en", 32'(wr_en), 32'd0);
        cyc();
        pix_valid = 1'b0;
        check("ovf set", 32'(ovf_err), 32'd1);
        check("ovf stall", 32'(render_stall), 32'd1);
        check("ovf wr_addr", 32'(wr_addr), 32'd0);
        disp_vs = 1'b1;
        cyc();
        disp_vs = 1'b0;
        check("f3 frame_cnt", 32'(frame_cnt), 32'd3);
        check("f3 wr_bank", 32'(wr_bank), 32'd1);
        cyc();
        check("f3 restart", 32'(render_start), 32'd1);
        check("ovf sticky", 32'(ovf_err), 32'd1);

        // Reset mid-frame at pixel counter 5
        feed(5, 0);
        check("mid wr_addr", 32'(wr_addr), 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid rst wr_addr", 32'(wr_addr), 32'd0);
        check("mid rst wr_bank", 32'(wr_bank), 32'd0);
        check("mid rst rd_bank", 32'(rd_bank), 32'd1);
        check("mid rst ovf", 32'(ovf_err), 32'd0);
        check("mid rst frame", 32'(frame_cnt), 32'd0);
        check("mid rst dup", 32'(dup_cnt), 32'd0);
        check("mid rst stall", 32'(render_stall), 32'd1);
        cyc();
        check("mid c1 start", 32'(render_start), 32'd0);
        cyc();
        check("mid c2 start", 32'(render_start), 32'd1);
        feed(1, 0);
        check("mid new bank", 32'(wr_bank), 32'd0);
        check("mid next addr", 32'(wr_addr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 Parameter H_DISP, default 1280, active pixels per line.
REQ-002 Parameter V_DISP, default 720, active lines per frame; H_DISP*V_DISP SHALL be <= 2^20.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pix_valid  in  1  pipeline output pixel valid this cycle.
REQ-006 disp_vs  in  1  display vsync, one-cycle pulse, clk domain.
REQ-007 render_start  out  1  one-cycle pulse starting a pipeline frame.
REQ-008 render_stall  out  1  hold pipeline; no pix_valid expected while high.
REQ-009 wr_en  out  1  framebuffer write strobe.
REQ-010 wr_bank  out  1  bank being written.
REQ-011 wr_addr  out  20  pixel address within wr_bank.
REQ-012 rd_bank  out  1  bank scanned by display; always != wr_bank.
REQ-013 frame_cnt  out  16  completed swaps, wrapping.
REQ-014 dup_cnt  out  8  vsyncs with no new frame, saturating at 255.
REQ-015 ovf_err  out  1  sticky: pix_valid seen while stalled.

Function
REQ-016 FSM states SHALL be IDLE, RENDER, WAIT_VS, SWAP.
REQ-017 IDLE SHALL last one cycle, then assert render_start for one cycle and enter RENDER.
REQ-018 In RENDER, render_stall SHALL be 0.
REQ-019 In RENDER, wr_en SHALL combinationally equal pix_valid.
REQ-020 In RENDER, wr_addr SHALL equal the internal pixel counter pix_cnt.
REQ-021 pix_cnt SHALL increment on each accepted pixel.
REQ-022 The accepted pixel at pix_cnt == H_DISP*V_DISP-1 SHALL clear pix_cnt to 0 and move RENDER -> WAIT_VS.
REQ-023 In WAIT_VS, render_stall SHALL be 1 and wr_en SHALL be 0.
REQ-024 WAIT_VS -> SWAP on disp_vs.
REQ-025 A disp_vs arriving in the same cycle as the last pixel SHALL be latched as pending, and WAIT_VS SHALL proceed to SWAP on the next cycle.
REQ-026 SWAP SHALL last one cycle: toggle wr_bank and rd_bank, increment frame_cnt, keep render_stall at 1.
REQ-027 On the cycle after SWAP, render_start SHALL pulse and the FSM SHALL re-enter RENDER.
REQ-028 Bank toggles SHALL occur only in SWAP, so rd_bank changes only on the cycle after a disp_vs (or after a pending vsync).
REQ-029 disp_vs in RENDER, IDLE or SWAP (other than the pending case) SHALL increment dup_cnt (saturating) and SHALL NOT swap.
REQ-030 pix_valid outside RENDER SHALL be dropped (wr_en=0, pix_cnt unchanged) and SHALL set ovf_err.
REQ-031 All outputs SHALL be registered except wr_en and wr_addr.

Reset
REQ-032 On rst: FSM=IDLE, pix_cnt=0, wr_bank=0, rd_bank=1, frame_cnt=0, dup_cnt=0, ovf_err=0, render_start=0, render_stall=1, pending vsync=0.
REQ-033 rst mid-frame SHALL discard the partial frame; the first render_start SHALL follow 2 cycles after rst deasserts.

Structure
REQ-034 A shared pipeline package SHALL hold the state encoding (2 bits) and the FRAME_PIX = H_DISP*V_DISP-1 constant.
REQ-035 The pixel address counter SHALL be one sub-module, fb_addr_cnt (enable, clear, terminal-count output); all else inline.

Verification
REQ-036 Reset, no stimulus: render_start pulses at cycle 2 after rst low; render_stall=0 from cycle 2; rd_bank=1, wr_bank=0.
REQ-037 H_DISP=4, V_DISP=2, 8 consecutive pix_valid: wr_addr 0..7; FSM in WAIT_VS after the 8th; disp_vs 5 cycles later -> banks swap next cycle, frame_cnt=1, render_start one cycle after SWAP.
REQ-038 disp_vs on the same cycle as the 8th pixel: swap happens 2 cycles later; dup_cnt=0.
REQ-039 3 disp_vs pulses during RENDER: dup_cnt=3, banks unchanged; 300 pulses: dup_cnt=255.
REQ-040 pix_valid during WAIT_VS: wr_en=0, ovf_err=1 and remains 1 until rst.
REQ-041 rst asserted at pix_cnt=5: pix_cnt=0 and banks restored; next frame writes from address 0 into bank 0.
